// File: rtl/qarctan_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the
// quantized arctangent stage of the FM demodulator.
package qarctan_pkg;

  // Fraction bits of the fixed-point angle; QUANTIZE(v) = v << QUANT_BITS.
  localparam int unsigned QUANT_BITS_DEFAULT = 10;

  // round(pi/4 * 2^10) and 3*pi/4 at the same scale.
  localparam int QUAD1 = 804;
  localparam int QUAD3 = 3 * QUAD1;

  // Working width for the dequantize helper; products up to 2*64 bits fit.
  localparam int unsigned PROD_MAX_W = 128;

  typedef logic signed [PROD_MAX_W-1:0] prod_max_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StMul,
    StOut
  } state_t;

  // Divide by 2^qbits, truncating toward zero. A plain arithmetic shift
  // rounds toward minus infinity, so negative values are biased first.
  function automatic prod_max_t dequantize(input prod_max_t prod, input int unsigned qbits);
    prod_max_t bias;
    bias = (prod_max_t'(1) << qbits) - prod_max_t'(1);
    if (prod < 0) begin
      dequantize = (prod + bias) >>> qbits;
    end else begin
      dequantize = prod >>> qbits;
    end
  endfunction

endpackage

// File: rtl/qarctan_div_ctrl.sv
// Quantized arctangent controller. Accepts one (y, x) product sample, forms
// the qarctan ratio operands for an external signed iterative divider, waits
// for the quotient and converts it into a fixed-point angle.
module qarctan_div_ctrl
  import qarctan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QUANT_BITS = QUANT_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  // Sample input
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [DATA_WIDTH-1:0] in_x,
  // Divider interface
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic                  div_overflow,
  input  logic                  div_done,
  // Angle output
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_angle,
  output logic                  out_err
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  localparam logic signed [PW-1:0]         QUAD1_W  = PW'(QUAD1);
  localparam logic signed [DATA_WIDTH-1:0] QUAD1_DW = DATA_WIDTH'(QUAD1);
  localparam logic signed [DATA_WIDTH-1:0] QUAD3_DW = DATA_WIDTH'(QUAD3);

  state_t state_q;

  // Registered sample and intermediate results
  logic signed [DATA_WIDTH-1:0] y_q;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] base_q;
  logic signed [DATA_WIDTH-1:0] quot_q;
  logic                         ovf_q;

  // Operand formation
  logic signed [DATA_WIDTH-1:0] abs_y;
  logic signed [DATA_WIDTH-1:0] issue_dvd;
  logic signed [DATA_WIDTH-1:0] issue_dvs;
  logic signed [DATA_WIDTH-1:0] issue_base;

  // Angle reconstruction
  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] deq;
  logic signed [DATA_WIDTH-1:0] mag;
  logic signed [DATA_WIDTH-1:0] angle;

  // Ratio operands from the registered sample; the +1 keeps the divisor
  // nonzero for y = 0, x = 0 and all arithmetic wraps at DATA_WIDTH.
  always_comb begin
    abs_y = (y_q[DATA_WIDTH-1] ? -y_q : y_q) + DATA_WIDTH'(1);
    if (!x_q[DATA_WIDTH-1]) begin
      issue_dvd  = (x_q - abs_y) <<< QUANT_BITS;
      issue_dvs  = x_q + abs_y;
      issue_base = QUAD1_DW;
    end else begin
      issue_dvd  = (x_q + abs_y) <<< QUANT_BITS;
      issue_dvs  = abs_y - x_q;
      issue_base = QUAD3_DW;
    end
  end

  // Scale the quotient by pi/4, remove the fraction and fold in the quadrant.
  always_comb begin
    prod  = QUAD1_W * PW'(quot_q);
    deq   = DATA_WIDTH'(dequantize(PROD_MAX_W'(prod), QUANT_BITS));
    mag   = base_q - deq;
    angle = y_q[DATA_WIDTH-1] ? -mag : mag;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      in_ready     <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_valid    <= 1'b0;
      out_angle    <= '0;
      out_err      <= 1'b0;
      y_q          <= '0;
      x_q          <= '0;
      base_q       <= '0;
      quot_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready is still low on the first cycle out of reset.
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            y_q      <= in_y;
            x_q      <= in_x;
            in_ready <= 1'b0;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          div_dividend <= issue_dvd;
          div_divisor  <= issue_dvs;
          base_q       <= issue_base;
          div_start    <= 1'b1;
          state_q      <= StWait;
        end
        StWait: begin
          // Operands are left untouched: the divider re-reads them on completion.
          div_start <= 1'b0;
          if (div_done) begin
            quot_q  <= div_quotient;
            ovf_q   <= div_overflow;
            state_q <= StMul;
          end
        end
        StMul: begin
          if (ovf_q) begin
            out_angle <= '0;
            out_err   <= 1'b1;
          end else begin
            out_angle <= angle;
            out_err   <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          div_start <= 1'b0;
          out_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qarctan_div_ctrl.sv
// Directed bench for qarctan_div_ctrl with a behavioural signed divider peer.
module tb_qarctan_div_ctrl;

  localparam int DW      = 32;
  localparam int DIV_LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_y;
  logic [DW-1:0] in_x;
  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic [DW-1:0] div_quotient;
  logic          div_overflow;
  logic          div_done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_angle;
  logic          out_err;

  logic div_done_m;
  logic stray;
  logic force_ovf;

  int checks = 0;
  int errors = 0;

  assign div_done = div_done_m | stray;

  always #5 clk = ~clk;

  qarctan_div_ctrl #(
    .DATA_WIDTH(DW),
    .QUANT_BITS(10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_y        (in_y),
    .in_x        (in_x),
    .div_start   (div_start),
    .div_dividend(div_dividend),
    .div_divisor (div_divisor),
    .div_quotient(div_quotient),
    .div_overflow(div_overflow),
    .div_done    (div_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_angle   (out_angle),
    .out_err     (out_err)
  );

  // Divider peer: fixed latency, reads operands at completion, truncates toward zero.
  logic busy;
  int   cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= 1'b0;
      cnt          <= 0;
      div_done_m   <= 1'b0;
      div_quotient <= '0;
      div_overflow <= 1'b0;
    end else begin
      div_done_m <= 1'b0;
      if (div_start) begin
        busy <= 1'b1;
        cnt  <= DIV_LAT;
      end else if (busy) begin
        if (cnt <= 1) begin
          busy       <= 1'b0;
          div_done_m <= 1'b1;
          if (div_divisor == '0) begin
            div_quotient <= '0;
            div_overflow <= 1'b1;
          end else begin
            div_quotient <= $signed(div_dividend) / $signed(div_divisor);
            div_overflow <= force_ovf;
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid.
  task automatic do_sample(input string name, input logic signed [31:0] y,
                           input logic signed [31:0] x, input logic signed [31:0] exp_dvd,
                           input logic signed [31:0] exp_dvs, input logic signed [31:0] exp_q,
                           input logic signed [31:0] exp_ang, input logic exp_err,
                           input int hold);
    logic signed [31:0] cap_dvd;
    logic signed [31:0] cap_dvs;
    logic signed [31:0] q_seen;
    logic acc;
    logic got_start;
    logic got_out;
    logic stable;
    logic bp_ok;
    int   starts;
    acc       = 1'b0;
    got_start = 1'b0;
    got_out   = 1'b0;
    stable    = 1'b1;
    bp_ok     = 1'b1;
    starts    = 0;
    cap_dvd   = '0;
    cap_dvs   = '0;
    q_seen    = '0;
    @(negedge clk);
    in_y     = y;
    in_x     = x;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "/accept"}, 32'(acc), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (div_start) begin
        got_start = 1'b1;
        starts++;
        cap_dvd = div_dividend;
        cap_dvs = div_divisor;
        break;
      end
      @(negedge clk);
    end
    check({name, "/start_seen"}, 32'(got_start), 1);
    check({name, "/dividend"}, cap_dvd, exp_dvd);
    check({name, "/divisor"}, cap_dvs, exp_dvs);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (div_start) starts++;
      if (div_dividend !== cap_dvd || div_divisor !== cap_dvs) stable = 1'b0;
      if (div_done) q_seen = div_quotient;
      if (out_valid) begin
        got_out = 1'b1;
        break;
      end
    end
    check({name, "/out_valid"}, 32'(got_out), 1);
    check({name, "/start_pulses"}, starts, 1);
    check({name, "/operands_stable"}, 32'(stable), 1);
    check({name, "/quotient"}, q_seen, exp_q);
    check({name, "/angle"}, out_angle, exp_ang);
    check({name, "/err"}, 32'(out_err), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!out_valid || out_angle !== exp_ang || out_err !== exp_err || in_ready) bp_ok = 1'b0;
    end
    if (hold > 0) check({name, "/hold"}, 32'(bp_ok), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "/valid_drop"}, 32'(out_valid), 0);
    check({name, "/ready_back"}, 32'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic stray_ok;
    logic got_start;
    in_valid  = 1'b0;
    in_y      = '0;
    in_x      = '0;
    out_ready = 1'b0;
    stray     = 1'b0;
    force_ovf = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/in_ready", 32'(in_ready), 0);
    check("rst/div_start", 32'(div_start), 0);
    check("rst/dividend", div_dividend, 0);
    check("rst/divisor", div_divisor, 0);
    check("rst/out_valid", 32'(out_valid), 0);
    check("rst/out_angle", out_angle, 0);
    check("rst/out_err", 32'(out_err), 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst/ready_after", 32'(in_ready), 1);

    do_sample("y0_x100", 0, 100, 101376, 101, 1003, 17, 1'b0, 0);
    do_sample("y100_x0", 100, 0, -103424, 101, -1024, 1608, 1'b0, 0);
    do_sample("yn100_x0", -100, 0, -103424, 101, -1024, -1608, 1'b0, 0);
    do_sample("y0_xn100", 0, -100, -101376, 101, -1003, 3199, 1'b0, 0);
    do_sample("backpressure", 100, 0, -103424, 101, -1024, 1608, 1'b0, 5);
    force_ovf = 1'b1;
    do_sample("overflow", 100, 0, -103424, 101, -1024, 0, 1'b1, 0);
    force_ovf = 1'b0;
    do_sample("post_ovf", 0, 100, 101376, 101, 1003, 17, 1'b0, 0);

    // Abandon a sample while the divider is busy.
    got_start = 1'b0;
    @(negedge clk);
    in_y     = 0;
    in_x     = 100;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (div_start) begin
        got_start = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midwait/start_seen", 32'(got_start), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midwait/in_ready", 32'(in_ready), 0);
    check("midwait/div_start", 32'(div_start), 0);
    check("midwait/dividend", div_dividend, 0);
    check("midwait/divisor", div_divisor, 0);
    check("midwait/out_valid", 32'(out_valid), 0);
    check("midwait/out_angle", out_angle, 0);
    check("midwait/out_err", 32'(out_err), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    stray_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || div_start || !in_ready) stray_ok = 1'b0;
    end
    check("stray_done/ignored", 32'(stray_ok), 1);
    do_sample("after_reset", 0, 100, 101376, 101, 1003, 17, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
